// File: rtl/smm_tile_accum.sv
// Sums KDEPTH consecutive 4-lane 2x2 block products into one output tile,
// flagging any signed lane overflow seen while the tile was built.
module smm_tile_accum #(
   parameter int DATAWIDTH = 32,
   parameter int BUSWIDTH  = 4*DATAWIDTH,
   parameter int KDEPTH    = 2,
   parameter int CNTWIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BUSWIDTH-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [BUSWIDTH-1:0] out_data,
   output logic                out_ovf,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CNTWIDTH-1:0] tile_cnt,
   output logic                busy
);

   localparam int BCW = (KDEPTH > 1) ? $clog2(KDEPTH) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(KDEPTH-1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   logic [BCW-1:0]      beat_cnt_q, beat_cnt_d;
   logic [BUSWIDTH-1:0] acc_q, acc_d;
   logic                ovf_acc_q, ovf_acc_d;
   logic [BUSWIDTH-1:0] out_data_q, out_data_d;
   logic                out_ovf_q, out_ovf_d;
   logic                out_valid_q, out_valid_d;
   logic [CNTWIDTH-1:0] tile_cnt_q, tile_cnt_d;

   logic [0:0]          state;
   logic                last_beat;
   logic                accept;
   logic [BUSWIDTH-1:0] sum;
   logic                ovf_this;
   logic [DATAWIDTH-1:0] lane_a [4];
   logic [DATAWIDTH-1:0] lane_b [4];
   logic [DATAWIDTH-1:0] lane_s [4];
   logic [3:0]          lane_ovf;

   assign state     = (beat_cnt_q != '0) ? ACCUM : IDLE;
   assign last_beat = (beat_cnt_q == LAST_BEAT);
   assign in_ready  = !rst && (!last_beat || !out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;

   // The first beat of a tile adds to zero, so it can never flag overflow.
   always_comb begin
      lane_a   = '{default: '0};
      lane_b   = '{default: '0};
      lane_s   = '{default: '0};
      lane_ovf = '0;
      sum      = '0;
      for (int i = 0; i < 4; i++) begin
         lane_a[i]   = (state == ACCUM) ? acc_q[DATAWIDTH*i +: DATAWIDTH] : '0;
         lane_b[i]   = in_data[DATAWIDTH*i +: DATAWIDTH];
         lane_s[i]   = lane_a[i] + lane_b[i];
         lane_ovf[i] = (lane_a[i][DATAWIDTH-1] == lane_b[i][DATAWIDTH-1]) &&
                       (lane_s[i][DATAWIDTH-1] != lane_a[i][DATAWIDTH-1]);
         sum[DATAWIDTH*i +: DATAWIDTH] = lane_s[i];
      end
   end

   assign ovf_this = |lane_ovf;

   // A final beat landing while the output drains overwrites it and keeps out_valid high.
   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      acc_d       = acc_q;
      ovf_acc_d   = ovf_acc_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q;
      tile_cnt_d  = tile_cnt_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (last_beat) begin
            out_data_d  = sum;
            out_ovf_d   = ovf_acc_q | ovf_this;
            out_valid_d = 1'b1;
            acc_d       = '0;
            ovf_acc_d   = 1'b0;
            beat_cnt_d  = '0;
            tile_cnt_d  = tile_cnt_q + CNTWIDTH'(1);
         end else begin
            acc_d       = sum;
            ovf_acc_d   = ovf_acc_q | ovf_this;
            beat_cnt_d  = beat_cnt_q + BCW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         acc_q       <= '0;
         ovf_acc_q   <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
         tile_cnt_q  <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         acc_q       <= acc_d;
         ovf_acc_q   <= ovf_acc_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
         tile_cnt_q  <= tile_cnt_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;
   assign tile_cnt  = tile_cnt_q;
   assign busy      = (state == ACCUM);

endmodule

// File: tb/tb_smm_tile_accum.sv
// Directed bench for smm_tile_accum: a KDEPTH=2 instance for accumulation,
// overflow, backpressure and reset, and a KDEPTH=1 instance for the pass-through case.
module tb_smm_tile_accum;

   logic clk;
   logic rst;

   logic [127:0] a_in_data;
   logic         a_in_valid;
   logic         a_in_ready;
   logic [127:0] a_out_data;
   logic         a_out_ovf;
   logic         a_out_valid;
   logic         a_out_ready;
   logic [15:0]  a_tile_cnt;
   logic         a_busy;

   logic [127:0] b_in_data;
   logic         b_in_valid;
   logic         b_in_ready;
   logic [127:0] b_out_data;
   logic         b_out_ovf;
   logic         b_out_valid;
   logic         b_out_ready;
   logic [1:0]   b_tile_cnt;
   logic         b_busy;

   int vectors;
   int miscompares;

   smm_tile_accum #(.DATAWIDTH(32), .KDEPTH(2), .CNTWIDTH(16)) dut_a (
      .clk(clk), .rst(rst),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_ovf(a_out_ovf), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .tile_cnt(a_tile_cnt), .busy(a_busy)
   );

   smm_tile_accum #(.DATAWIDTH(32), .KDEPTH(1), .CNTWIDTH(2)) dut_b (
      .clk(clk), .rst(rst),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_ovf(b_out_ovf), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .tile_cnt(b_tile_cnt), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] pack(input logic [31:0] l3, input logic [31:0] l2,
                                         input logic [31:0] l1, input logic [31:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [127:0] d, input logic r);
      a_in_valid  = v;
      a_in_data   = d;
      a_out_ready = r;
   endtask

   task automatic applyStimulus(input logic v, input logic [127:0] d, input logic r);
      drive(v, d, r);
      tick();
   endtask

   initial begin
      int exp_cnt [5];
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      drive(1'b0, '0, 1'b1);
      b_in_valid  = 1'b0;
      b_in_data   = '0;
      b_out_ready = 1'b1;
      tick();
      tick();

      checkOutput("rst_in_ready",  128'(a_in_ready),  128'd0);
      checkOutput("rst_out_valid", 128'(a_out_valid), 128'd0);
      checkOutput("rst_out_data",  a_out_data,        128'd0);
      checkOutput("rst_tile_cnt",  128'(a_tile_cnt),  128'd0);
      checkOutput("rst_busy",      128'(a_busy),      128'd0);

      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", 128'(a_in_ready), 128'd1);

      // Basic tile
      applyStimulus(1'b1, pack(4, 3, 2, 1), 1'b1);
      checkOutput("basic_busy_mid",  128'(a_busy),      128'd1);
      checkOutput("basic_valid_mid", 128'(a_out_valid), 128'd0);
      applyStimulus(1'b1, pack(10, 20, 30, 40), 1'b1);
      checkOutput("basic_valid", 128'(a_out_valid), 128'd1);
      checkOutput("basic_data",  a_out_data,        pack(14, 23, 32, 41));
      checkOutput("basic_ovf",   128'(a_out_ovf),   128'd0);
      checkOutput("basic_cnt",   128'(a_tile_cnt),  128'd1);
      checkOutput("basic_busy",  128'(a_busy),      128'd0);

      // Positive overflow on lane0
      applyStimulus(1'b1, pack(0, 0, 0, 32'h7FFFFFFF), 1'b1);
      checkOutput("ovf_drained", 128'(a_out_valid), 128'd0);
      applyStimulus(1'b1, pack(0, 0, 0, 32'h00000001), 1'b1);
      checkOutput("ovf_data", a_out_data,       pack(0, 0, 0, 32'h80000000));
      checkOutput("ovf_flag", 128'(a_out_ovf),  128'd1);
      checkOutput("ovf_cnt",  128'(a_tile_cnt), 128'd2);

      // Mixed-sign sum must not overflow, and the sticky flag must have cleared
      applyStimulus(1'b1, pack(0, 0, 0, 32'hFFFFFFFB), 1'b1);
      applyStimulus(1'b1, pack(0, 0, 0, 32'h00000003), 1'b1);
      checkOutput("neg_data", a_out_data,      pack(0, 0, 0, 32'hFFFFFFFE));
      checkOutput("neg_flag", 128'(a_out_ovf), 128'd0);

      // Negative overflow on lane3
      applyStimulus(1'b1, pack(32'h80000000, 7, 0, 0), 1'b1);
      applyStimulus(1'b1, pack(32'hFFFFFFFF, 1, 0, 0), 1'b1);
      checkOutput("novf_data", a_out_data,       pack(32'h7FFFFFFF, 8, 0, 0));
      checkOutput("novf_flag", 128'(a_out_ovf),  128'd1);
      checkOutput("novf_cnt",  128'(a_tile_cnt), 128'd4);

      // Backpressure
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("bp_empty", 128'(a_out_valid), 128'd0);
      applyStimulus(1'b1, pack(1, 2, 3, 4), 1'b0);
      applyStimulus(1'b1, pack(5, 5, 5, 5), 1'b0);
      checkOutput("bp_t1_valid", 128'(a_out_valid), 128'd1);
      checkOutput("bp_t1_data",  a_out_data,        pack(6, 7, 8, 9));
      checkOutput("bp_t1_cnt",   128'(a_tile_cnt),  128'd5);
      applyStimulus(1'b1, pack(100, 100, 100, 100), 1'b0);
      checkOutput("bp_b3_busy", 128'(a_busy),     128'd1);
      checkOutput("bp_b3_hold", a_out_data,       pack(6, 7, 8, 9));
      drive(1'b1, pack(1, 2, 3, 4), 1'b0);
      #1;
      checkOutput("bp_b4_stall", 128'(a_in_ready), 128'd0);
      tick();
      checkOutput("bp_stall_hold", a_out_data,       pack(6, 7, 8, 9));
      checkOutput("bp_stall_busy", 128'(a_busy),     128'd1);
      checkOutput("bp_stall_cnt",  128'(a_tile_cnt), 128'd5);
      drive(1'b1, pack(1, 2, 3, 4), 1'b1);
      #1;
      checkOutput("bp_b4_ready", 128'(a_in_ready), 128'd1);
      tick();
      checkOutput("bp_t2_valid", 128'(a_out_valid), 128'd1);
      checkOutput("bp_t2_data",  a_out_data,        pack(101, 102, 103, 104));
      checkOutput("bp_t2_cnt",   128'(a_tile_cnt),  128'd6);
      checkOutput("bp_t2_busy",  128'(a_busy),      128'd0);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("bp_drain", 128'(a_out_valid), 128'd0);

      // Reset in the middle of a tile
      applyStimulus(1'b1, pack(9, 9, 9, 9), 1'b1);
      checkOutput("mr_busy", 128'(a_busy), 128'd1);
      rst = 1'b1;
      drive(1'b0, '0, 1'b1);
      #1;
      checkOutput("mr_in_ready", 128'(a_in_ready), 128'd0);
      tick();
      rst = 1'b0;
      checkOutput("mr_busy_clr", 128'(a_busy),     128'd0);
      checkOutput("mr_cnt_clr",  128'(a_tile_cnt), 128'd0);
      applyStimulus(1'b1, pack(1, 1, 1, 1), 1'b1);
      applyStimulus(1'b1, pack(2, 2, 2, 2), 1'b1);
      checkOutput("mr_data",  a_out_data,       pack(3, 3, 3, 3));
      checkOutput("mr_cnt",   128'(a_tile_cnt), 128'd1);
      checkOutput("mr_valid", 128'(a_out_valid), 128'd1);
      drive(1'b0, '0, 1'b1);

      // KDEPTH=1 pass-through with a 2-bit wrapping tile counter
      checkOutput("k1_idle_valid", 128'(b_out_valid), 128'd0);
      exp_cnt = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
         b_in_valid  = 1'b1;
         b_in_data   = pack(32'(i), 32'(i + 100), 32'hA5A5_0000 + 32'(i), 32'(7 * i + 11));
         b_out_ready = 1'b1;
         tick();
         checkOutput($sformatf("k1_valid_%0d", i), 128'(b_out_valid), 128'd1);
         checkOutput($sformatf("k1_data_%0d", i), b_out_data,
                     pack(32'(i), 32'(i + 100), 32'hA5A5_0000 + 32'(i), 32'(7 * i + 11)));
         checkOutput($sformatf("k1_cnt_%0d", i), 128'(b_tile_cnt), 128'(exp_cnt[i]));
      end
      b_in_valid = 1'b0;
      tick();
      checkOutput("k1_drain", 128'(b_out_valid), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
